uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 16x-oversampling 8N1 UART receiver with a first-word-fall-through
//            receive FIFO and single-cycle framing / overrun error pulses.
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            rx_serial_i    - asynchronous serial line, idle high
//            rx_data_o      - registered byte at the FIFO head
//            rx_valid_o     - FIFO non-empty, rx_data_o valid
//            rx_ready_i     - consumer pop (pops when rx_valid_o & rx_ready_i)
//            fifo_count_o   - current FIFO occupancy
//            framing_err_o  - one-cycle pulse, stop bit sampled low
//            overrun_err_o  - one-cycle pulse, byte dropped on a full FIFO
//            rx_busy_o      - receiver FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_TICK = 54,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_serial_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          framing_err_o,
  output logic                          overrun_err_o,
  output logic                          rx_busy_o
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_tw = $clog2(CLKS_PER_TICK);
  localparam logic [c_tw-1:0] c_tick_last = c_tw'(CLKS_PER_TICK - 1);
  localparam logic [c_cw-1:0] c_depth     = c_cw'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchronizer; idles high so reset does not look like a start edge.
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial_i;
      rx_s_q  <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Receiver FSM with tick generator, sample/bit counters and shift register.
  // --------------------------------------------------------------------------
  state_e          state_q;
  logic [c_tw-1:0] tick_cnt_q;
  logic [3:0]      sample_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            framing_q;
  logic            w_tick;
  logic            w_push_req;

  assign w_tick = (tick_cnt_q == c_tick_last);

  // Stop bit sampled high: the assembled byte is offered to the FIFO.
  assign w_push_req = (state_q == ST_STOP) && w_tick && (sample_q == 4'd15) && rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      sample_q   <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      framing_q  <= 1'b0;
    end else begin
      framing_q  <= 1'b0;
      tick_cnt_q <= w_tick ? '0 : tick_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q    <= ST_START;
            sample_q   <= '0;
            // Realign the tick phase to the start edge.
            tick_cnt_q <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (sample_q == 4'd7) begin
              if (rx_s_q) begin
                state_q <= ST_IDLE;
              end else begin
                sample_q <= '0;
                bit_q    <= '0;
                state_q  <= ST_DATA;
              end
            end else begin
              sample_q <= sample_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            sample_q <= sample_q + 4'd1;
            if (sample_q == 4'd15) begin
              // LSB arrives first, so shift right and fill from the top.
              shift_q <= {rx_s_q, shift_q[7:1]};
              if (bit_q == 3'd7) begin
                state_q <= ST_STOP;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            sample_q <= sample_q + 4'd1;
            if (sample_q == 4'd15) begin
              if (rx_s_q) begin
                state_q <= ST_IDLE;
              end else begin
                framing_q <= 1'b1;
                state_q   <= ST_BREAK;
              end
            end
          end
        end
        ST_BREAK: begin
          // Hold here for the whole low period so a break yields one error.
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through, registered head).
  // --------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0] count_q, count_d;
  logic [c_cw-1:0] w_remain;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q;
  logic            overrun_q;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic            w_overrun;

  always_comb begin
    w_pop     = rx_valid_q & rx_ready_i;
    w_full    = (count_q == c_depth);
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    w_push    = w_push_req & (~w_full | w_pop);
    w_overrun = w_push_req & w_full & ~w_pop;
    count_d   = count_q + c_cw'(w_push) - c_cw'(w_pop);
    rd_ptr_d  = rd_ptr_q + c_aw'(w_pop);
    wr_ptr_d  = wr_ptr_q + c_aw'(w_push);
    w_remain  = count_q - c_cw'(w_pop);
    // Next head: the incoming byte if nothing older remains, else storage.
    if (w_remain == '0) begin
      rx_data_d = w_push ? shift_q : rx_data_q;
    end else begin
      rx_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= (count_d != '0);
      overrun_q  <= w_overrun;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign fifo_count_o  = count_q;
  assign framing_err_o = framing_q;
  assign overrun_err_o = overrun_q;
  assign rx_busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo
//            (CLKS_PER_TICK=4 -> 64 clk per bit, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CLKS_PER_TICK = 4;
  localparam int FIFO_DEPTH    = 4;
  localparam int BIT_CLKS      = 16 * CLKS_PER_TICK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [2:0] fifo_count_o;
  logic       framing_err_o;
  logic       overrun_err_o;
  logic       rx_busy_o;

  uart_rx_fifo #(
    .CLKS_PER_TICK (CLKS_PER_TICK),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_serial_i   (rx_serial),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready),
    .fifo_count_o  (fifo_count_o),
    .framing_err_o (framing_err_o),
    .overrun_err_o (overrun_err_o),
    .rx_busy_o     (rx_busy_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int fr_cnt = 0;
  int ov_cnt = 0;

  // Count cycles each error pulse is high, so width and count are both seen.
  always @(negedge clk) begin
    if (framing_err_o) fr_cnt++;
    if (overrun_err_o) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is #1 after a posedge; each bit is held exactly BIT_CLKS cycles.
  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    rx_serial = 1'b1;
  endtask

  task automatic pop_chk(input logic [7:0] exp, input string tag);
    chk({tag, "_valid"}, 32'(rx_valid_o), 32'd1);
    chk({tag, "_data"}, 32'(rx_data_o), 32'(exp));
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] pat [4];
    int lat;
    int f0;
    int o0;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55; pat[3] = 8'h3C;

    // ---------------- reset ----------------
    repeat (10) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rx_valid_o),    32'd0);
    chk("rst_count", 32'(fifo_count_o),  32'd0);
    chk("rst_ferr",  32'(framing_err_o), 32'd0);
    chk("rst_oerr",  32'(overrun_err_o), 32'd0);
    chk("rst_busy",  32'(rx_busy_o),     32'd0);
    chk("rst_data",  32'(rx_data_o),     32'h00);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // ---------------- first byte and latency ----------------
    f0 = fr_cnt; o0 = ov_cnt; lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (!rx_valid_o && lat < 2000) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    // Valid follows the mid-stop-bit sample plus synchronizer delay.
    chk("latency", 32'(lat >= 576 && lat <= 620), 32'd1);
    chk("a5_data",  32'(rx_data_o),    32'hA5);
    chk("a5_count", 32'(fifo_count_o), 32'd1);
    chk("a5_ferr",  32'(fr_cnt - f0),  32'd0);
    chk("a5_oerr",  32'(ov_cnt - o0),  32'd0);
    pop_chk(8'hA5, "a5_pop");
    chk("a5_empty", 32'(rx_valid_o), 32'd0);

    // ---------------- back-to-back, two passes for wrap ----------------
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) send_byte(pat[i], 1'b1);
      chk($sformatf("b2b%0d_count", p), 32'(fifo_count_o), 32'd4);
      for (int i = 0; i < 4; i++) pop_chk(pat[i], $sformatf("b2b%0d_pop%0d", p, i));
      chk($sformatf("b2b%0d_empty", p), 32'(fifo_count_o), 32'd0);
    end

    // ---------------- overrun ----------------
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    o0 = ov_cnt;
    send_byte(8'h77, 1'b1);
    chk("ovr_pulse", 32'(ov_cnt - o0),  32'd1);
    chk("ovr_count", 32'(fifo_count_o), 32'd4);
    chk("ovr_head",  32'(rx_data_o),    32'h11);

    // ---------------- simultaneous push/pop on a full FIFO ----------------
    o0 = ov_cnt;
    fork
      send_byte(8'h88, 1'b1);
      begin
        // Pop lands on the same edge that pushes the new byte.
        repeat (lat - 1) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    chk("pp_oerr",  32'(ov_cnt - o0),  32'd0);
    chk("pp_count", 32'(fifo_count_o), 32'd4);
    pop_chk(8'h22, "pp_pop0");
    pop_chk(8'h33, "pp_pop1");
    pop_chk(8'h44, "pp_pop2");
    pop_chk(8'h88, "pp_pop3");
    chk("pp_empty", 32'(rx_valid_o), 32'd0);

    // ---------------- framing error and break ----------------
    f0 = fr_cnt;
    send_byte(8'h12, 1'b0);
    rx_serial = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    chk("brk_ferr",  32'(fr_cnt - f0),  32'd1);
    chk("brk_count", 32'(fifo_count_o), 32'd0);
    send_byte(8'h34, 1'b1);
    chk("brk_count34", 32'(fifo_count_o), 32'd1);
    pop_chk(8'h34, "brk_pop34");

    // ---------------- false start ----------------
    f0 = fr_cnt; o0 = ov_cnt;
    rx_serial = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("fs_busy_hi", 32'(rx_busy_o), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("fs_busy_lo", 32'(rx_busy_o),     32'd0);
    chk("fs_count",   32'(fifo_count_o),  32'd0);
    chk("fs_errs",    32'(fr_cnt - f0 + ov_cnt - o0), 32'd0);

    // ---------------- mid-frame reset ----------------
    send_byte(8'h5A, 1'b1);
    chk("mr_pre_count", 32'(fifo_count_o), 32'd1);
    f0 = fr_cnt;
    fork
      send_byte(8'hC3, 1'b1);
      begin
        // Start bit plus bits 0..3, then reset through bit 5 into bit 6.
        repeat (5 * BIT_CLKS) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mr_rst_count", 32'(fifo_count_o), 32'd0);
        chk("mr_rst_valid", 32'(rx_valid_o),   32'd0);
        chk("mr_rst_data",  32'(rx_data_o),    32'h00);
        repeat (2 * BIT_CLKS + 8) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    repeat (100) @(posedge clk);
    #1;
    chk("mr_post_count", 32'(fifo_count_o), 32'd0);
    chk("mr_post_busy",  32'(rx_busy_o),    32'd0);
    chk("mr_post_ferr",  32'(fr_cnt - f0),  32'd0);
    send_byte(8'h96, 1'b1);
    chk("mr_clean_count", 32'(fifo_count_o), 32'd1);
    pop_chk(8'h96, "mr_clean_pop");
    chk("mr_final_empty", 32'(fifo_count_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
